// File: rtl/dmr_recovery_ctrl_pkg.sv
// Shared types for the DMR recovery controller: FSM state encoding, default
// halt timeout and the OBI instruction request bundle.
package dmr_recovery_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        RESYNC,
        RESUME,
        FATAL
    } dmr_rec_state_e;

    localparam int unsigned DEFAULT_HALT_TIMEOUT = 1024;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

endpackage

// File: rtl/dmr_recovery_ctrl.sv
// DMR recovery controller: halts the lockstep harts on a comparator mismatch and
// sequences the software resync. Build with DMR_ERR_LOG_EN to capture fetch addresses.
module dmr_recovery_ctrl
    import dmr_recovery_ctrl_pkg::*;
#(
    parameter int unsigned NHARTS       = 2,
    parameter int unsigned HALT_TIMEOUT = DEFAULT_HALT_TIMEOUT,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmr_en_i,
    input  logic                  error_i,
    input  logic [NHARTS-1:0]     core_debug_mode_i,
    input  logic                  resync_done_i,
    input  logic                  clr_cnt_i,
    input  obi_req_t              core_instr_req_i [NHARTS],
    output logic [NHARTS-1:0]     debug_req_o,
    output logic                  busy_o,
    output logic                  intr_o,
    output logic                  fatal_o,
    output logic [CNT_W-1:0]      err_cnt_o,
    output logic [NHARTS*32-1:0]  err_addr_o,
    output logic [2:0]            dbg_state_o
);

    localparam int unsigned TW = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(HALT_TIMEOUT - 1);

    dmr_rec_state_e   state_q, state_d;
    logic [TW-1:0]    timer_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic             intr_q;
    logic             accept;
    logic             unused_req;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A full halt beats an expiring timer when both happen in the same cycle.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dmr_en_i && error_i) begin
                    state_d = HALT;
                    accept  = 1'b1;
                end
            end
            HALT: begin
                if (&core_debug_mode_i) begin
                    state_d = RESYNC;
                end else if (timer_q == TIMER_MAX) begin
                    state_d = FATAL;
                end
            end
            RESYNC: begin
                if (resync_done_i) begin
                    state_d = RESUME;
                end
            end
            RESUME: begin
                if (~|core_debug_mode_i) begin
                    state_d = IDLE;
                end
            end
            FATAL:   state_d = FATAL;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timer_q   <= '0;
            intr_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (state_q == HALT && state_d == HALT) begin
                timer_q <= timer_q + TW'(1);
            end else begin
                timer_q <= '0;
            end
            intr_q <= (state_d == RESYNC) && (state_q != RESYNC);
            // Clear first, then count, so a coincident error leaves a count of one.
            if (clr_cnt_i) begin
                err_cnt_q <= accept ? CNT_W'(1) : '0;
            end else if (accept && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

    assign debug_req_o = (state_q == HALT || state_q == FATAL) ? '1 : '0;
    assign busy_o      = (state_q != IDLE);
    assign fatal_o     = (state_q == FATAL);
    assign intr_o      = intr_q;
    assign err_cnt_o   = err_cnt_q;
    assign dbg_state_o = state_q;

`ifdef DMR_ERR_LOG_EN
    logic [NHARTS*32-1:0] err_addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_addr_q <= '0;
        end else if (accept) begin
            for (int h = 0; h < NHARTS; h++) begin
                err_addr_q[h*32 +: 32] <= core_instr_req_i[h].addr;
            end
        end
    end

    assign err_addr_o = err_addr_q;
`else
    assign err_addr_o = '0;
`endif

    // Request fields not consumed by the capture logic are folded away here.
    always_comb begin
        unused_req = 1'b0;
        for (int h = 0; h < NHARTS; h++) begin
            unused_req = unused_req ^ (^core_instr_req_i[h]);
        end
    end

endmodule
